// File: rtl/jt49_amp_mix_if.sv
// Bus between the PSG core and the amplitude mixer: snapshot inputs in, mixed sample out.
// Latency: none; this only bundles wires.
// Backpressure: none; each conversion is started by a single cen pulse.
interface jt49_amp_mix_if;
    logic       cen;
    logic [2:0] tone;
    logic       noise;
    logic [5:0] mixer;
    logic [4:0] amp_a;
    logic [4:0] amp_b;
    logic [4:0] amp_c;
    logic [3:0] env;
    logic [7:0] ch_a;
    logic [7:0] ch_b;
    logic [7:0] ch_c;
    logic [9:0] sound;
    logic       sample;
    logic       ovr;

    modport master (
        output cen, tone, noise, mixer, amp_a, amp_b, amp_c, env,
        input  ch_a, ch_b, ch_c, sound, sample, ovr
    );

    modport slave (
        input  cen, tone, noise, mixer, amp_a, amp_b, amp_c, env,
        output ch_a, ch_b, ch_c, sound, sample, ovr
    );
endinterface

// File: rtl/jt49_amp_mix.sv
// Per-channel level select and gating, shared log table time-multiplexed over A/B/C, 10-bit sum.
// Latency: cen accepted at edge N -> sample strobe in the cycle after edge N+4.
// Backpressure: none; cen arriving while busy is dropped and raises the sticky ovr flag.
module jt49_amp_mix #(
    parameter bit LINEAR = 1'b0
) (
    input  logic           clk,
    input  logic           rst,
    jt49_amp_mix_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        CHA  = 3'd1,
        CHB  = 3'd2,
        CHC  = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t     state_q, state_d;
    logic       start;
    logic       busy_cen;

    // Snapshot of the inputs taken when a conversion starts
    logic [2:0] tone_q;
    logic       noise_q;
    logic [5:0] mixer_q;
    logic [4:0] amp_a_q, amp_b_q, amp_c_q;
    logic [3:0] env_q;

    logic [9:0] acc_q;
    logic [7:0] hold_a_q, hold_b_q, hold_c_q;
    logic [7:0] ch_a_q, ch_b_q, ch_c_q;
    logic [9:0] sound_q;
    logic       sample_q;
    logic       ovr_q;

    logic [4:0] sel_amp;
    logic       sel_tone, sel_tdis, sel_ndis;
    logic       gate;
    logic [3:0] level;
    logic [7:0] lin;

    // 4-bit level to 8-bit linear amplitude; log curve roughly 3 dB per step
    function automatic logic [7:0] to_lin(input logic [3:0] lvl);
        logic [7:0] r;
        if (LINEAR) begin
            r = {lvl, lvl};
        end else begin
            unique case (lvl)
                4'd0:  r = 8'd0;
                4'd1:  r = 8'd2;
                4'd2:  r = 8'd3;
                4'd3:  r = 8'd4;
                4'd4:  r = 8'd6;
                4'd5:  r = 8'd8;
                4'd6:  r = 8'd11;
                4'd7:  r = 8'd16;
                4'd8:  r = 8'd23;
                4'd9:  r = 8'd32;
                4'd10: r = 8'd45;
                4'd11: r = 8'd64;
                4'd12: r = 8'd90;
                4'd13: r = 8'd128;
                4'd14: r = 8'd180;
                default: r = 8'd255;
            endcase
        end
        return r;
    endfunction

    // State register; reset aborts any conversion in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Sequencer: one clock per channel, then a publish cycle; cen only honoured in IDLE
    always_comb begin
        state_d  = state_q;
        start    = 1'b0;
        busy_cen = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.cen) begin
                    state_d = CHA;
                    start   = 1'b1;
                end
            end
            CHA:     state_d = CHB;
            CHB:     state_d = CHC;
            CHC:     state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (state_q != IDLE && bus.cen) begin
            busy_cen = 1'b1;
        end
    end

    // Route the channel being converted this cycle into the shared gate/table path
    always_comb begin
        sel_amp  = amp_a_q;
        sel_tone = tone_q[0];
        sel_tdis = mixer_q[0];
        sel_ndis = mixer_q[3];
        unique case (state_q)
            CHB: begin
                sel_amp  = amp_b_q;
                sel_tone = tone_q[1];
                sel_tdis = mixer_q[1];
                sel_ndis = mixer_q[4];
            end
            CHC: begin
                sel_amp  = amp_c_q;
                sel_tone = tone_q[2];
                sel_tdis = mixer_q[2];
                sel_ndis = mixer_q[5];
            end
            default: ;
        endcase
        // Mixer bits are active-low enables: a set bit forces that source "on"
        gate  = (sel_tone | sel_tdis) & (noise_q | sel_ndis);
        level = gate ? (sel_amp[4] ? env_q : sel_amp[3:0]) : 4'd0;
        lin   = to_lin(level);
    end

    // Snapshot, per-channel accumulate, and publish all outputs together on the DONE edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tone_q   <= '0;
            noise_q  <= 1'b0;
            mixer_q  <= '0;
            amp_a_q  <= '0;
            amp_b_q  <= '0;
            amp_c_q  <= '0;
            env_q    <= '0;
            acc_q    <= '0;
            hold_a_q <= '0;
            hold_b_q <= '0;
            hold_c_q <= '0;
            ch_a_q   <= '0;
            ch_b_q   <= '0;
            ch_c_q   <= '0;
            sound_q  <= '0;
            sample_q <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            sample_q <= (state_q == DONE);
            if (busy_cen) begin
                ovr_q <= 1'b1;
            end
            if (start) begin
                tone_q  <= bus.tone;
                noise_q <= bus.noise;
                mixer_q <= bus.mixer;
                amp_a_q <= bus.amp_a;
                amp_b_q <= bus.amp_b;
                amp_c_q <= bus.amp_c;
                env_q   <= bus.env;
                acc_q   <= '0;
            end
            // Three 8-bit terms peak at 765, so the 10-bit sum cannot wrap
            unique case (state_q)
                CHA: begin
                    hold_a_q <= lin;
                    acc_q    <= acc_q + {2'b00, lin};
                end
                CHB: begin
                    hold_b_q <= lin;
                    acc_q    <= acc_q + {2'b00, lin};
                end
                CHC: begin
                    hold_c_q <= lin;
                    acc_q    <= acc_q + {2'b00, lin};
                end
                DONE: begin
                    sound_q <= acc_q;
                    ch_a_q  <= hold_a_q;
                    ch_b_q  <= hold_b_q;
                    ch_c_q  <= hold_c_q;
                end
                default: ;
            endcase
        end
    end

    assign bus.ch_a   = ch_a_q;
    assign bus.ch_b   = ch_b_q;
    assign bus.ch_c   = ch_c_q;
    assign bus.sound  = sound_q;
    assign bus.sample = sample_q;
    assign bus.ovr    = ovr_q;

endmodule

// File: tb/tb_jt49_amp_mix.sv
// Bench for jt49_amp_mix: log and linear builds driven in parallel, scoreboard-checked.
// Latency: expected samples are due four edges after the accepting edge.
// Backpressure: checks that cen inside a conversion is dropped and ovr latches.
module tb_jt49_amp_mix;

    logic       clk = 1'b0;
    logic       rst;
    logic       cen;
    logic [2:0] tone;
    logic       noise;
    logic [5:0] mixer;
    logic [4:0] amp_a, amp_b, amp_c;
    logic [3:0] env;

    always #5 clk = ~clk;

    jt49_amp_mix_if bus_log ();
    jt49_amp_mix_if bus_lin ();

    assign bus_log.cen   = cen;
    assign bus_log.tone  = tone;
    assign bus_log.noise = noise;
    assign bus_log.mixer = mixer;
    assign bus_log.amp_a = amp_a;
    assign bus_log.amp_b = amp_b;
    assign bus_log.amp_c = amp_c;
    assign bus_log.env   = env;
    assign bus_lin.cen   = cen;
    assign bus_lin.tone  = tone;
    assign bus_lin.noise = noise;
    assign bus_lin.mixer = mixer;
    assign bus_lin.amp_a = amp_a;
    assign bus_lin.amp_b = amp_b;
    assign bus_lin.amp_c = amp_c;
    assign bus_lin.env   = env;

    jt49_amp_mix #(.LINEAR(1'b0)) dut_log (.clk(clk), .rst(rst), .bus(bus_log));
    jt49_amp_mix #(.LINEAR(1'b1)) dut_lin (.clk(clk), .rst(rst), .bus(bus_lin));

    typedef struct {
        int edge_n;
        int la, lb, lc, ls;
        int na, nb, nc, ns;
    } exp_t;

    exp_t q[$];
    int   vectors    = 0;
    int   miscompares = 0;

    // ---------------- reference model ----------------
    int log_tab [16] = '{0, 2, 3, 4, 6, 8, 11, 16, 23, 32, 45, 64, 90, 128, 180, 255};
    int edge_n     = 0;
    int last_start = -100;
    int ovr_m      = 0;

    function automatic int ch_level(int x, int amp, int tn, int nz, int mx, int ev);
        int t, td, nd;
        t  = (tn >> x) & 1;
        td = (mx >> x) & 1;
        nd = (mx >> (x + 3)) & 1;
        if (((t | td) & (nz | nd)) == 0) return 0;
        if ((amp & 16) != 0) return ev;
        return amp & 15;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ovr_m      = 0;
            last_start = -100;
        end else begin
            edge_n++;
            if (cen === 1'b1) begin
                if (edge_n - last_start >= 5) begin
                    exp_t e;
                    int la, lb, lc;
                    la = ch_level(0, int'(amp_a), int'(tone), int'(noise), int'(mixer), int'(env));
                    lb = ch_level(1, int'(amp_b), int'(tone), int'(noise), int'(mixer), int'(env));
                    lc = ch_level(2, int'(amp_c), int'(tone), int'(noise), int'(mixer), int'(env));
                    e.edge_n = edge_n;
                    e.la = log_tab[la]; e.lb = log_tab[lb]; e.lc = log_tab[lc];
                    e.ls = e.la + e.lb + e.lc;
                    e.na = la * 17;     e.nb = lb * 17;     e.nc = lc * 17;
                    e.ns = e.na + e.nb + e.nc;
                    q.push_back(e);
                    last_start = edge_n;
                end else begin
                    ovr_m = 1;
                end
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    exp_t cur = '{0, 0, 0, 0, 0, 0, 0, 0, 0};

    task automatic chk(input string name, input int got, input int want);
        vectors++;
        if (got != want) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, got, want, edge_n);
        end
    endtask

    always begin
        @(negedge clk or posedge rst);
        #1;
        if (rst) begin
            q.delete();
            cur = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
        end else begin
            if (bus_log.sample === 1'b1) begin
                if (q.size() == 0) begin
                    chk("unexpected_sample", 1, 0);
                end else begin
                    cur = q.pop_front();
                    chk("sample_latency", edge_n, cur.edge_n + 4);
                end
            end
            if (q.size() > 0 && q[0].edge_n + 4 < edge_n) begin
                chk("missing_sample", 0, 1);
                void'(q.pop_front());
            end
        end
        chk("sample_lin_vs_log", int'(bus_lin.sample), int'(bus_log.sample));
        chk("log_ch_a",  int'(bus_log.ch_a),  cur.la);
        chk("log_ch_b",  int'(bus_log.ch_b),  cur.lb);
        chk("log_ch_c",  int'(bus_log.ch_c),  cur.lc);
        chk("log_sound", int'(bus_log.sound), cur.ls);
        chk("lin_ch_a",  int'(bus_lin.ch_a),  cur.na);
        chk("lin_ch_b",  int'(bus_lin.ch_b),  cur.nb);
        chk("lin_ch_c",  int'(bus_lin.ch_c),  cur.nc);
        chk("lin_sound", int'(bus_lin.sound), cur.ns);
        chk("log_ovr",   int'(bus_log.ovr),   rst ? 0 : ovr_m);
        chk("lin_ovr",   int'(bus_lin.ovr),   rst ? 0 : ovr_m);
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_in(input logic [5:0] mx, input logic [2:0] tn, input logic nz,
                          input logic [4:0] a, input logic [4:0] b, input logic [4:0] c,
                          input logic [3:0] ev);
        mixer = mx; tone = tn; noise = nz;
        amp_a = a;  amp_b = b; amp_c = c; env = ev;
    endtask

    // One cen pulse followed by enough idle clocks to respect the 5-clock spacing
    task automatic conv(input logic [5:0] mx, input logic [2:0] tn, input logic nz,
                        input logic [4:0] a, input logic [4:0] b, input logic [4:0] c,
                        input logic [3:0] ev);
        set_in(mx, tn, nz, a, b, c, ev);
        cen = 1'b1;
        tick();
        cen = 1'b0;
        repeat (4) tick();
    endtask

    initial begin
        rst = 1'b1;
        cen = 1'b0;
        set_in(6'h00, 3'b000, 1'b0, 5'h00, 5'h00, 5'h00, 4'h0);
        repeat (3) tick();
        rst = 1'b0;
        repeat (2) tick();

        // Fixed volumes with everything forced on
        conv(6'h3F, 3'b000, 1'b0, 5'h0F, 5'h08, 5'h00, 4'h0);
        repeat (2) tick();

        // Envelope select; env changes right after the start must not matter
        set_in(6'h3F, 3'b000, 1'b0, 5'h10, 5'h10, 5'h10, 4'hD);
        cen = 1'b1;
        tick();
        cen = 1'b0;
        env = 4'h0;
        repeat (5) tick();

        // Gating through tone and noise enables
        conv(6'b111110, 3'b000, 1'b0, 5'h0F, 5'h00, 5'h00, 4'h0);
        conv(6'b111110, 3'b001, 1'b0, 5'h0F, 5'h00, 5'h00, 4'h0);
        conv(6'b110111, 3'b000, 1'b0, 5'h0F, 5'h00, 5'h00, 4'h0);
        conv(6'b110111, 3'b000, 1'b1, 5'h0F, 5'h00, 5'h00, 4'h0);

        // Linear-build reference points (log build checked alongside)
        conv(6'h3F, 3'b000, 1'b0, 5'h05, 5'h00, 5'h00, 4'h0);
        conv(6'h3F, 3'b000, 1'b0, 5'h0F, 5'h0F, 5'h0F, 4'h0);

        // Back-to-back at exactly 5-clock spacing: no overrun
        conv(6'h3F, 3'b000, 1'b0, 5'h0C, 5'h03, 5'h1A, 4'h7);
        conv(6'h3F, 3'b000, 1'b0, 5'h01, 5'h0E, 5'h09, 4'h2);
        repeat (3) tick();

        // Reset in the middle of a conversion (during CHB)
        set_in(6'h3F, 3'b000, 1'b0, 5'h0F, 5'h0F, 5'h0F, 4'h0);
        cen = 1'b1;
        tick();
        cen = 1'b0;
        tick();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        repeat (6) tick();
        conv(6'h3F, 3'b000, 1'b0, 5'h0A, 5'h04, 5'h13, 4'h9);
        repeat (2) tick();

        // Overrun: second cen two clocks after the first is dropped; ovr latches
        set_in(6'h3F, 3'b000, 1'b0, 5'h06, 5'h07, 5'h08, 4'h0);
        cen = 1'b1;
        tick();
        cen = 1'b0;
        amp_a = 5'h0F;
        tick();
        cen = 1'b1;
        tick();
        cen = 1'b0;
        repeat (6) tick();

        // cen held high: a conversion every 5 clocks
        cen = 1'b1;
        repeat (16) tick();
        cen = 1'b0;
        repeat (6) tick();

        // Clear ovr, then randomized traffic with inputs moving every clock
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        tick();
        for (int i = 0; i < 400; i++) begin
            set_in(6'($urandom), 3'($urandom), 1'($urandom), 5'($urandom),
                   5'($urandom), 5'($urandom), 4'($urandom));
            cen = ($urandom_range(0, 4) == 0);
            tick();
        end
        cen = 1'b0;
        repeat (10) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
